// File: rtl/math_seq_unit.sv
// Sequential CSR math engine: mul/div/mod/sqrt with CTRL/STATUS/RES handshake.
// Define MATH_SEQ_SIGNED_EN to enable signed ops 4-6 (MULS/DIVS/MODS).
`ifndef HBIT_TGT_CSR
`define HBIT_TGT_CSR 3
`endif
`ifndef CSR_IDX_MATH_CTRL
`define CSR_IDX_MATH_CTRL 8
`endif
`ifndef CSR_IDX_MATH_STATUS
`define CSR_IDX_MATH_STATUS 9
`endif
`ifndef CSR_IDX_MATH_RES0
`define CSR_IDX_MATH_RES0 10
`endif
`ifndef CSR_IDX_MATH_RES1
`define CSR_IDX_MATH_RES1 11
`endif

module math_seq_unit #(
  parameter int W  = 24,
  parameter int AW = `HBIT_TGT_CSR+1
) (
  input  logic          iw_clk,
  input  logic          iw_rst_n,
  input  logic [W-1:0]  iw_math_ctrl,
  input  logic [W-1:0]  iw_math_opa,
  input  logic [W-1:0]  iw_math_opb,
  output logic          ow_csr_wen,
  output logic [AW-1:0] ow_csr_waddr,
  output logic [W-1:0]  ow_csr_wdata
);
  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_BUSYW, S_RUN, S_RES0, S_RES1, S_STAT
  } state_t;

  localparam int CW = $clog2(W) + 1;
  localparam logic [AW-1:0] A_CTRL = AW'(`CSR_IDX_MATH_CTRL);
  localparam logic [AW-1:0] A_ST   = AW'(`CSR_IDX_MATH_STATUS);
  localparam logic [AW-1:0] A_R0   = AW'(`CSR_IDX_MATH_RES0);
  localparam logic [AW-1:0] A_R1   = AW'(`CSR_IDX_MATH_RES1);

  function automatic logic op_ok(input logic [3:0] op);
`ifdef MATH_SEQ_SIGNED_EN
    return op <= 4'd6;
`else
    return op <= 4'd3;
`endif
  endfunction
  function automatic logic op_mul(input logic [3:0] op);
    return op == 4'd0 || op == 4'd4;
  endfunction
  function automatic logic op_dv(input logic [3:0] op);
    return op == 4'd1 || op == 4'd5;
  endfunction
  function automatic logic op_md(input logic [3:0] op);
    return op == 4'd2 || op == 4'd6;
  endfunction
  function automatic logic op_sq(input logic [3:0] op);
    return op == 4'd3;
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [W-1:0]  hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dz_q, dz_d, il_q, il_d, ab_q, ab_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [W-1:0]  wdata_q, wdata_d;

  logic [3:0]    op_in;
  logic [W-1:0]  a_in, b_in;
  assign op_in = iw_math_ctrl[4:1];

`ifdef MATH_SEQ_SIGNED_EN
  logic nq_q, nq_d, nr_q, nr_d;
  logic sg_in;
  assign sg_in = op_in inside {4'd4, 4'd5, 4'd6};
  // Engine is unsigned: feed magnitudes, fix signs on the way out
  assign a_in = (sg_in && iw_math_opa[W-1]) ? -iw_math_opa : iw_math_opa;
  assign b_in = (sg_in && iw_math_opb[W-1]) ? -iw_math_opb : iw_math_opb;
`else
  assign a_in = iw_math_opa;
  assign b_in = iw_math_opb;
`endif

  logic [W:0]   sum, dt;
  logic [W-1:0] rs, tr;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    il_d    = il_q;
    ab_d    = ab_q;
`ifdef MATH_SEQ_SIGNED_EN
    nq_d    = nq_q;
    nr_d    = nr_q;
`endif
    sum     = '0;
    dt      = '0;
    rs      = '0;
    tr      = '0;
    unique case (state_q)
      S_IDLE: if (iw_math_ctrl[0]) begin
        state_d = S_ACK;
        op_d    = op_in;
        hi_d    = '0;
        lo_d    = a_in;
        b_d     = op_sq(op_in) ? '0 : b_in;
        cnt_d   = op_sq(op_in) ? CW'(W/2-1) : CW'(W-1);
        il_d    = !op_ok(op_in);
        dz_d    = op_ok(op_in) && (op_dv(op_in) || op_md(op_in))
                  && iw_math_opb == '0;
        ab_d    = 1'b0;
`ifdef MATH_SEQ_SIGNED_EN
        nq_d    = sg_in && (iw_math_opa[W-1] ^ iw_math_opb[W-1]);
        nr_d    = sg_in && iw_math_opa[W-1];
`endif
      end
      S_ACK:   state_d = S_BUSYW;
      S_BUSYW: state_d = (dz_q || il_q) ? S_RES0 : S_RUN;
      S_RUN: if (iw_math_ctrl[5]) begin
        state_d = S_STAT;
        ab_d    = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_RES0;
        unique case (1'b1)
          op_mul(op_q): begin
            sum          = {1'b0, hi_q} + {1'b0, b_q & {W{lo_q[0]}}};
            {hi_d, lo_d} = {sum, lo_q[W-1:1]};
          end
          op_sq(op_q): begin
            // b_q holds the partial root, hi_q the running remainder
            rs   = {hi_q[W-3:0], lo_q[W-1:W-2]};
            tr   = {b_q[W-3:0], 2'b01};
            lo_d = {lo_q[W-3:0], 2'b00};
            if (rs >= tr) begin
              hi_d = rs - tr;
              b_d  = {b_q[W-2:0], 1'b1};
            end else begin
              hi_d = rs;
              b_d  = {b_q[W-2:0], 1'b0};
            end
          end
          default: begin
            dt = {hi_q, lo_q[W-1]} - {1'b0, b_q};
            if (!dt[W]) begin
              hi_d = dt[W-1:0];
              lo_d = {lo_q[W-2:0], 1'b1};
            end else begin
              hi_d = {hi_q[W-2:0], lo_q[W-1]};
              lo_d = {lo_q[W-2:0], 1'b0};
            end
          end
        endcase
      end
      S_RES0:  state_d = S_RES1;
      S_RES1:  state_d = S_STAT;
      S_STAT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rem, res0, res1;
  logic           zr;

  always_comb begin
`ifdef MATH_SEQ_SIGNED_EN
    prod = nq_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo  = nq_q ? -lo_q : lo_q;
    rem  = nr_q ? -hi_q : hi_q;
`else
    prod = {hi_q, lo_q};
    quo  = lo_q;
    rem  = hi_q;
`endif
    zr   = dz_q || il_q;
    res0 = '0;
    res1 = '0;
    if (!zr) begin
      unique case (1'b1)
        op_mul(op_q): begin
          res0 = prod[W-1:0];
          res1 = prod[2*W-1:W];
        end
        op_sq(op_q): res0 = b_q;
        op_dv(op_q): begin
          res0 = quo;
          res1 = rem;
        end
        default: res0 = rem;
      endcase
    end
  end

  always_comb begin
    wen_d   = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    unique case (state_q)
      S_ACK: begin
        wen_d   = 1'b1;
        waddr_d = A_CTRL;
        wdata_d = iw_math_ctrl & ~W'(33);
      end
      S_BUSYW: begin
        wen_d   = 1'b1;
        waddr_d = A_ST;
        wdata_d = W'(2);
      end
      S_RES0: begin
        wen_d   = 1'b1;
        waddr_d = A_R0;
        wdata_d = res0;
      end
      S_RES1: begin
        wen_d   = 1'b1;
        waddr_d = A_R1;
        wdata_d = res1;
      end
      S_STAT: begin
        wen_d   = 1'b1;
        waddr_d = A_ST;
        wdata_d = W'({il_q, ab_q, dz_q, 2'b01});
      end
      default: ;
    endcase
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      il_q    <= 1'b0;
      ab_q    <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
`ifdef MATH_SEQ_SIGNED_EN
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      il_q    <= il_d;
      ab_q    <= ab_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
`ifdef MATH_SEQ_SIGNED_EN
      nq_q    <= nq_d;
      nr_q    <= nr_d;
`endif
    end
  end

  assign ow_csr_wen   = wen_q;
  assign ow_csr_waddr = waddr_q;
  assign ow_csr_wdata = wdata_q;

endmodule

// File: tb/tb_math_seq_unit.sv
// Directed bench for math_seq_unit: vector table plus abort/reset/restart sequences.
`ifndef HBIT_TGT_CSR
`define HBIT_TGT_CSR 3
`endif
`ifndef CSR_IDX_MATH_CTRL
`define CSR_IDX_MATH_CTRL 8
`endif
`ifndef CSR_IDX_MATH_STATUS
`define CSR_IDX_MATH_STATUS 9
`endif
`ifndef CSR_IDX_MATH_RES0
`define CSR_IDX_MATH_RES0 10
`endif
`ifndef CSR_IDX_MATH_RES1
`define CSR_IDX_MATH_RES1 11
`endif

module tb_math_seq_unit;
  localparam int W  = 24;
  localparam int AW = `HBIT_TGT_CSR+1;
  localparam logic [AW-1:0] A_CTRL = AW'(`CSR_IDX_MATH_CTRL);
  localparam logic [AW-1:0] A_ST   = AW'(`CSR_IDX_MATH_STATUS);
  localparam logic [AW-1:0] A_R0   = AW'(`CSR_IDX_MATH_RES0);
  localparam logic [AW-1:0] A_R1   = AW'(`CSR_IDX_MATH_RES1);
  localparam logic [W-1:0]  CTRL_X = 24'h000100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  ctrl, opa, opb;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wdata;

  math_seq_unit #(.W(W)) dut (
    .iw_clk       (clk),
    .iw_rst_n     (rst_n),
    .iw_math_ctrl (ctrl),
    .iw_math_opa  (opa),
    .iw_math_opb  (opb),
    .ow_csr_wen   (wen),
    .ow_csr_waddr (waddr),
    .ow_csr_wdata (wdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int nw;
  bit done;
  logic [AW-1:0] wa [16];
  logic [W-1:0]  wd [16];
  int            wk [16];

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           n;
    logic [W-1:0] r0;
    logic [W-1:0] r1;
    logic [W-1:0] st;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  // Cycle 0: START driven; cycle k: k-th clock period after the sampling edge
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold,
                        input int abort_k, input int maxk, input bit stop);
    nw   = 0;
    done = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wa[i] = '0;
      wd[i] = '0;
      wk[i] = 0;
    end
    @(negedge clk);
    ctrl = CTRL_X | W'({op, 1'b1});
    opa  = a;
    opb  = b;
    for (int k = 1; k <= maxk && !done; k++) begin
      @(posedge clk);
      #1;
      ctrl[0] = (k <= hold);
      ctrl[5] = (k == abort_k);
      @(negedge clk);
      if (wen) begin
        if (nw < 16) begin
          wa[nw] = waddr;
          wd[nw] = wdata;
          wk[nw] = k;
        end
        nw++;
        if (stop && waddr == A_ST && wdata[0]) done = 1'b1;
      end
    end
    ctrl = '0;
    if (stop && !done) begin
      checks++;
      errors++;
      $display("FAIL timeout op %0d got no STATUS ready write", op);
    end
  endtask

  task automatic watch(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (wen) cnt++;
    end
  endtask

  task automatic chk_run(input string nm, input vec_t v);
    chk({nm, " nwrites"}, 64'(nw), 64'(5));
    chk({nm, " addrs"}, {wa[0], wa[1], wa[2], wa[3], wa[4]},
        {A_CTRL, A_ST, A_R0, A_R1, A_ST});
    chk({nm, " ctrl"}, wd[0], CTRL_X | W'({v.op, 1'b0}));
    chk({nm, " busy"}, wd[1], 24'h000002);
    chk({nm, " res0"}, wd[2], v.r0);
    chk({nm, " res1"}, wd[3], v.r1);
    chk({nm, " stat"}, wd[4], v.st);
    chk({nm, " statcyc"}, 64'(wk[4]), 64'(6 + v.n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    vq.push_back('{4'd0, 24'hFFFFFF, 24'hFFFFFF, 24, 24'h000001, 24'hFFFFFE, 24'h01});
    vq.push_back('{4'd0, 24'h000003, 24'h000004, 24, 24'h00000C, 24'h000000, 24'h01});
    vq.push_back('{4'd0, 24'h123456, 24'h000010, 24, 24'h234560, 24'h000001, 24'h01});
    vq.push_back('{4'd1, 24'd100,    24'd7,      24, 24'd14,     24'd2,      24'h01});
    vq.push_back('{4'd1, 24'd5,      24'd0,      0,  24'd0,      24'd0,      24'h05});
    vq.push_back('{4'd1, 24'hFFFFFF, 24'h000001, 24, 24'hFFFFFF, 24'h000000, 24'h01});
    vq.push_back('{4'd2, 24'd100,    24'd7,      24, 24'd2,      24'd0,      24'h01});
    vq.push_back('{4'd2, 24'd9,      24'd0,      0,  24'd0,      24'd0,      24'h05});
    vq.push_back('{4'd3, 24'hFFFFFF, 24'd0,      12, 24'h000FFF, 24'd0,      24'h01});
    vq.push_back('{4'd3, 24'h000000, 24'd0,      12, 24'h000000, 24'd0,      24'h01});
    vq.push_back('{4'd3, 24'h0F4240, 24'd0,      12, 24'h0003E8, 24'd0,      24'h01});
    vq.push_back('{4'd3, 24'd99,     24'd0,      12, 24'd9,      24'd0,      24'h01});
    vq.push_back('{4'd7, 24'd1,      24'd1,      0,  24'd0,      24'd0,      24'h11});
    vq.push_back('{4'd15, 24'd1,     24'd0,      0,  24'd0,      24'd0,      24'h11});
`ifdef MATH_SEQ_SIGNED_EN
    vq.push_back('{4'd4, 24'hFFFFFF, 24'h000001, 24, 24'hFFFFFF, 24'hFFFFFF, 24'h01});
    vq.push_back('{4'd5, 24'hFFFFF9, 24'h000002, 24, 24'hFFFFFD, 24'hFFFFFF, 24'h01});
    vq.push_back('{4'd5, 24'h800000, 24'hFFFFFF, 24, 24'h800000, 24'h000000, 24'h01});
    vq.push_back('{4'd6, 24'hFFFFF9, 24'h000002, 24, 24'hFFFFFF, 24'h000000, 24'h01});
    vq.push_back('{4'd5, 24'h000007, 24'h000000, 0,  24'd0,      24'd0,      24'h05});
`else
    vq.push_back('{4'd4, 24'hFFFFFF, 24'h000001, 0, 24'd0, 24'd0, 24'h11});
    vq.push_back('{4'd5, 24'hFFFFF9, 24'h000000, 0, 24'd0, 24'd0, 24'h11});
    vq.push_back('{4'd6, 24'hFFFFF9, 24'h000002, 0, 24'd0, 24'd0, 24'h11});
`endif

    rst_n = 1'b0;
    ctrl  = '0;
    opa   = '0;
    opb   = '0;
    repeat (3) @(negedge clk);
    chk("reset wen", 64'(wen), 64'(0));
    chk("reset waddr", 64'(waddr), 64'(0));
    chk("reset wdata", 64'(wdata), 64'(0));
    rst_n = 1'b1;

    foreach (vq[i]) begin
      run_op(vq[i].op, vq[i].a, vq[i].b, 1, 0, 80, 1'b1);
      chk_run($sformatf("v%0d", i), vq[i]);
    end

    // ABORT in the fifth RUN cycle of DIVU
    run_op(4'd1, 24'd100, 24'd7, 1, 7, 80, 1'b1);
    chk("abort nwrites", 64'(nw), 64'(3));
    chk("abort addrs", {wa[0], wa[1], wa[2]}, {A_CTRL, A_ST, A_ST});
    chk("abort busy", wd[1], 24'h000002);
    chk("abort stat", wd[2], 24'h000009);
    chk("abort statcyc", 64'(wk[2]), 64'(9));

    // START held through STAT restarts on the cycle after STAT
    run_op(4'd1, 24'd5, 24'd0, 7, 0, 14, 1'b0);
    chk("hold nwrites", 64'(nw), 64'(10));
    chk("hold stat1", wd[4], 24'h000005);
    chk("hold stat1cyc", 64'(wk[4]), 64'(6));
    chk("hold ctrl2 addr", 64'(wa[5]), 64'(A_CTRL));
    chk("hold ctrl2cyc", 64'(wk[5]), 64'(8));
    chk("hold stat2", wd[9], 24'h000005);
    chk("hold stat2cyc", 64'(wk[9]), 64'(12));

    // Async reset while a write is on the outputs
    @(negedge clk);
    ctrl = CTRL_X | 24'h000001;
    opa  = 24'd3;
    opb  = 24'd4;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    ctrl = '0;
    chk("pre-rst wen", 64'(wen), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("async rst wen", 64'(wen), 64'(0));
    chk("async rst waddr", 64'(waddr), 64'(0));
    chk("async rst wdata", 64'(wdata), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    watch(40, cnt);
    chk("post-rst writes", 64'(cnt), 64'(0));

    // Reset in the middle of RUN
    @(negedge clk);
    ctrl = CTRL_X | 24'h000001;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) ctrl = '0;
    end
    rst_n = 1'b0;
    #1;
    chk("run rst wen", 64'(wen), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    watch(40, cnt);
    chk("run rst writes", 64'(cnt), 64'(0));
    run_op(4'd0, 24'd3, 24'd4, 1, 0, 80, 1'b1);
    chk_run("mul after rst",
            '{4'd0, 24'd3, 24'd4, 24, 24'd12, 24'd0, 24'h01});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
